ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 171 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define EX_MULDIV_DIV_EN to build the divide datapath; otherwise divide requests complete with no HI/LO write.
module ex_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] opnd_a,
    input  logic [DATA_WIDTH-1:0] opnd_b,
    input  logic                  cancel,
    output logic                  stall_req,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out,
    output logic                  hilo_wen,
    output logic                  div_by_zero
);

    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           count;
    logic [DATA_WIDTH-1:0]   hi_reg, lo_reg, opnd_reg;
    logic                    neg_lo, div_op;
    logic                    accept, last_iter, a_neg, b_neg;
    logic [DATA_WIDTH-1:0]   a_abs, b_abs;
    logic [DATA_WIDTH:0]     mul_sum;
    logic [2*DATA_WIDTH-1:0] mul_res;
`ifdef EX_MULDIV_DIV_EN
    logic                    neg_hi, dbz_reg, b_zero, div_ok;
    logic [DATA_WIDTH:0]     div_shift, div_diff;
`endif

    assign accept    = (state == IDLE) && start && !cancel;
    assign last_iter = (count == CW'(DATA_WIDTH - 1));
    assign a_neg     = op[0] & opnd_a[DATA_WIDTH-1];
    assign b_neg     = op[0] & opnd_b[DATA_WIDTH-1];
    assign a_abs     = a_neg ? -opnd_a : opnd_a;
    assign b_abs     = b_neg ? -opnd_b : opnd_b;
    assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    assign mul_res   = neg_lo ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
`ifdef EX_MULDIV_DIV_EN
    assign b_zero    = (opnd_b == '0);
    assign div_shift = {hi_reg, lo_reg[DATA_WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_reg};
    assign div_ok    = (div_shift >= {1'b0, opnd_reg});
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!op[1])
                        state_nxt = MUL;
                    else
`ifdef EX_MULDIV_DIV_EN
                        state_nxt = b_zero ? DONE : DIV;
`else
                        state_nxt = DONE;
`endif
                end
            end
            MUL:  if (last_iter) state_nxt = DONE;
`ifdef EX_MULDIV_DIV_EN
            DIV:  if (last_iter) state_nxt = DONE;
`else
            DIV:  state_nxt = IDLE;
`endif
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (cancel)
            state_nxt = IDLE;
    end

    // hi_reg/lo_reg hold the running product for MUL and remainder/quotient for DIV
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            opnd_reg <= '0;
            neg_lo   <= 1'b0;
            div_op   <= 1'b0;
`ifdef EX_MULDIV_DIV_EN
            neg_hi   <= 1'b0;
            dbz_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        count    <= '0;
                        div_op   <= op[1];
                        neg_lo   <= a_neg ^ b_neg;
                        hi_reg   <= '0;
                        lo_reg   <= b_abs;
                        opnd_reg <= a_abs;
`ifdef EX_MULDIV_DIV_EN
                        neg_hi   <= 1'b0;
                        dbz_reg  <= 1'b0;
                        if (op[1]) begin
                            if (b_zero) begin
                                hi_reg  <= opnd_a;
                                lo_reg  <= '1;
                                neg_lo  <= 1'b0;
                                dbz_reg <= 1'b1;
                            end else begin
                                lo_reg   <= a_abs;
                                opnd_reg <= b_abs;
                                neg_hi   <= a_neg;
                            end
                        end
`endif
                    end
                end
                MUL: begin
                    hi_reg <= mul_sum[DATA_WIDTH:1];
                    lo_reg <= {mul_sum[0], lo_reg[DATA_WIDTH-1:1]};
                    count  <= count + CW'(1);
                end
`ifdef EX_MULDIV_DIV_EN
                DIV: begin
                    hi_reg <= div_ok ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
                    lo_reg <= {lo_reg[DATA_WIDTH-2:0], div_ok};
                    count  <= count + CW'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    // Results are only driven during the single DONE cycle; zero otherwise
    always_comb begin
        done        = !rst && !cancel && (state == DONE);
        stall_req   = !rst && !cancel && (accept || state == MUL || state == DIV);
        hi_out      = '0;
        lo_out      = '0;
        div_by_zero = 1'b0;
`ifdef EX_MULDIV_DIV_EN
        hilo_wen    = done;
`else
        hilo_wen    = done && !div_op;
`endif
        if (done) begin
            if (!div_op) begin
                {hi_out, lo_out} = mul_res;
            end else begin
`ifdef EX_MULDIV_DIV_EN
                lo_out      = neg_lo ? -lo_reg : lo_reg;
                hi_out      = neg_hi ? -hi_reg : hi_reg;
                div_by_zero = dbz_reg;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv (DATA_WIDTH=32); expectations follow EX_MULDIV_DIV_EN if defined.
module tb_ex_muldiv;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        logic         wen;
        int           lat;
        int           start_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] opnd_a = '0;
    logic [W-1:0] opnd_b = '0;
    logic         cancel = 1'b0;
    logic         stall_req, done, hilo_wen, div_by_zero;
    logic [W-1:0] hi_out, lo_out;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    ex_muldiv #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .opnd_a(opnd_a), .opnd_b(opnd_b), .cancel(cancel),
        .stall_req(stall_req), .done(done), .hi_out(hi_out), .lo_out(lo_out),
        .hilo_wen(hilo_wen), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] hi, input logic [W-1:0] lo,
                                input logic dbz, input logic wen, input int lat);
        exp_t e;
        e.hi = hi; e.lo = lo; e.dbz = dbz; e.wen = wen; e.lat = lat; e.start_cyc = 0;
        return e;
    endfunction

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa, sb2, sq, sr;
        longint unsigned ua, ub, p;
        sa = $signed(a);
        sb2 = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (o == 2'b00) begin
            p = ua * ub;
            return mk(p[63:32], p[31:0], 1'b0, 1'b1, W + 1);
        end
        if (o == 2'b01) begin
            p = sa * sb2;
            return mk(p[63:32], p[31:0], 1'b0, 1'b1, W + 1);
        end
`ifdef EX_MULDIV_DIV_EN
        if (b == '0)
            return mk(a, '1, 1'b1, 1'b1, 1);
        if (o == 2'b10) begin
            sq = ua / ub;
            sr = ua % ub;
        end else begin
            sq = sa / sb2;
            sr = sa % sb2;
        end
        return mk(sr[31:0], sq[31:0], 1'b0, 1'b1, W + 1);
`else
        sq = 0;
        sr = 0;
        return mk(sr[31:0], sq[31:0], 1'b0, 1'b0, 1);
`endif
    endfunction

    // Drives one start pulse, queues the expectation, and waits (bounded) for done
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input exp_t e);
        bit seen = 0;
        e.start_cyc = cyc;
        sb.push_back(e);
        op = o; opnd_a = a; opnd_b = b; start = 1'b1;
        @(negedge clk);
        checkOutput("stall_c0", stall_req, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n < 100; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            checkOutput("stall_busy", stall_req, 1'b1);
        end
        if (!seen) checkOutput("done_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                checkOutput("stray_done", done, 1'b0);
            end else begin
                e = sb.pop_front();
                checkOutput("hi_out", hi_out, e.hi);
                checkOutput("lo_out", lo_out, e.lo);
                checkOutput("div_by_zero", div_by_zero, e.dbz);
                checkOutput("hilo_wen", hilo_wen, e.wen);
                checkOutput("latency", cyc - e.start_cyc, e.lat);
                checkOutput("stall_done", stall_req, 1'b0);
            end
        end else begin
            checkOutput("idle_outs", {hilo_wen, div_by_zero, hi_out, lo_out}, '0);
        end
    end

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        int           k;

        $display("[TB] ex_muldiv bench start");
        @(negedge clk);
        checkOutput("rst_stall", stall_req, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_stall", stall_req, 1'b0);
        @(posedge clk); #1;

        applyStimulus(2'b01, 32'hFFFF_FFFD, 32'd5, mk(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1, 33));
        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1, 33));
        applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000, mk(32'h4000_0000, 32'h0, 1'b0, 1'b1, 33));
`ifdef EX_MULDIV_DIV_EN
        applyStimulus(2'b10, 32'd100, 32'd7, mk(32'd2, 32'd14, 1'b0, 1'b1, 33));
        applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1, 33));
        applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0, 32'h8000_0000, 1'b0, 1'b1, 33));
        applyStimulus(2'b10, 32'd5, 32'd0, mk(32'd5, 32'hFFFF_FFFF, 1'b1, 1'b1, 1));
        applyStimulus(2'b11, 32'hFFFF_FFF0, 32'd0, mk(32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1));
`else
        applyStimulus(2'b10, 32'd100, 32'd7, mk(32'h0, 32'h0, 1'b0, 1'b0, 1));
        applyStimulus(2'b11, 32'd5, 32'd0, mk(32'h0, 32'h0, 1'b0, 1'b0, 1));
`endif

        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 4 == 1) ra = -ra;
            applyStimulus(ro, ra, rb, model(ro, ra, rb));
        end

        // Cancel mid-multiply at cycle 10, then a clean follow-up
        op = 2'b00; opnd_a = 32'd1234; opnd_b = 32'd5678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 cancel = 1'b1;
        @(negedge clk);
        checkOutput("cancel_stall", stall_req, 1'b0);
        @(posedge clk); #1;
        cancel = 1'b0;
        @(negedge clk);
        checkOutput("after_cancel_stall", stall_req, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        applyStimulus(2'b00, 32'd3, 32'd4, mk(32'd0, 32'd12, 1'b0, 1'b1, 33));

        // Simultaneous start and cancel in IDLE
        op = 2'b01; opnd_a = 32'd7; opnd_b = 32'd9; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        checkOutput("start_cancel_stall", stall_req, 1'b0);
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        checkOutput("start_cancel_idle", stall_req, 1'b0);
        repeat (40) @(posedge clk);
        #1;

        // Reset at cycle 5 of an operation, then start held through DONE of next op
`ifdef EX_MULDIV_DIV_EN
        op = 2'b10;
`else
        op = 2'b00;
`endif
        opnd_a = 32'd1000; opnd_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_stall", stall_req, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("after_rst_stall", stall_req, 1'b0);
        @(posedge clk); #1;

        sb.push_back(mk(32'd0, 32'd77, 1'b0, 1'b1, 33));
        sb[sb.size()-1].start_cyc = cyc;
        op = 2'b00; opnd_a = 32'd7; opnd_b = 32'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) checkOutput("done_timeout2", 1'b0, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            checkOutput("ignored_start_stall", stall_req, 1'b0);
        end

        checkOutput("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
